sigma_timer_slave: RTL and testbench
====================================

Name: sigma_timer_slave

Overview:
- Memory-mapped 32-bit timer/compare peripheral. It is the responder end of the MemSplit32 split-transaction bus.
- Hangs off a crossbar slave port, alongside gpio, and is driven by tile or udm initiators.
- Provides a prescaled free-running/auto-reload counter, a compare match flag and a level interrupt output for a tile irq input.

Parameters:
- PRESC_W, 16, width of the prescaler register and prescaler counter.
- RST_COMPARE, 32'hFFFF_FFFF, reset value of the COMPARE register.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous reset, active-low
- bus_req  in  1  initiator request
- bus_we  in  1  1 = write, 0 = read
- bus_addr  in  32  byte address; only addr[4:2] is decoded
- bus_be  in  4  byte enables (writes only)
- bus_wdata  in  32  write data
- bus_ack  out  1  request accepted
- bus_resp  out  1  read response valid, one-cycle pulse
- bus_rdata  out  32  read data, valid when bus_resp=1
- irq_o  out  1  interrupt, level

Behaviour:
- Reset (rst_ni=0 at a clk_i edge):
  - CTRL=0, PRESCALE=0, COUNT=0, COMPARE=RST_COMPARE, STATUS=0.
  - Prescaler counter = 0.
  - bus_resp=0, bus_rdata=0, irq_o=0.
  - Reset mid-transaction drops any pending resp.
- Register map (addr[4:2]); addr[1:0] and addr[31:5] are ignored:
  - 0: CTRL, bit0 EN, bit1 AUTORELOAD, bit2 IRQ_EN; other bits read 0.
  - 1: PRESCALE, bits [PRESC_W-1:0]; upper bits read 0.
  - 2: COUNT, rw.
  - 3: COMPARE, rw.
  - 4: STATUS, bit0 MATCH; write 1 to clear.
  - 5-7: unmapped; reads return 0, writes are ignored.
- Handshake:
  - bus_ack = bus_req, combinational, every cycle; the block never stalls.
  - Write: takes effect at the edge where req & ack & we. Per-byte masking by bus_be; be=0 writes nothing. No resp is generated for writes.
  - Read: rdata is sampled from the register values at the accept edge. bus_resp=1 and bus_rdata are registered on the following cycle (latency 1).
  - Back-to-back reads produce back-to-back resp pulses.
  - bus_rdata holds its last value when resp=0.
- Timer:
  - Prescaler counter runs while EN=1. When it equals PRESCALE it produces a tick and wraps to 0; otherwise it increments.
  - PRESCALE=0 gives a tick every cycle.
  - EN=0 freezes both the prescaler counter and COUNT; there is no clearing.
  - On a tick with COUNT==COMPARE:
    - MATCH is set.
    - If AUTORELOAD=1, COUNT <= 0; otherwise COUNT <= COUNT+1 (mod 2^32).
  - On a tick with no match: COUNT <= COUNT+1; 0xFFFF_FFFF wraps to 0 without setting MATCH unless it equals COMPARE.
  - Writing PRESCALE resets the prescaler counter to 0.
- Priorities, same edge:
  - Software write to COUNT wins over a tick increment or reload.
  - MATCH set wins over a W1C clear.
  - A write to CTRL.EN applies from the next cycle.
- irq_o = MATCH & IRQ_EN, registered (updates one cycle after the MATCH or CTRL change).
- No combinational path from bus inputs to bus_resp or bus_rdata.

Test Plan:
- Reset and readback:
  - Hold rst_ni=0 for 3 cycles, then read addr 0x0C.
  - Required: ack same cycle, resp one cycle later with rdata=0xFFFF_FFFF; irq_o=0; reads of 0x00, 0x04, 0x08 and 0x10 all return 0.
- Byte-enable write:
  - Write COMPARE=0x1234_5678 with be=4'b1111, then write 0xAABB_CCDD with be=4'b0101.
  - Required: readback 0x12BB_56DD; write to 0x14 is ignored and a read of 0x14 returns 0.
- Prescaled count with auto-reload:
  - Set PRESCALE=3, COMPARE=2, CTRL=0b111.
  - Required: COUNT ticks every 4 cycles, 0→1→2→0.
  - Required: MATCH is set at the 2→0 tick, and irq_o goes to 1 one cycle after MATCH.
  - Write STATUS=1: MATCH and irq_o clear.
- Free-run wrap:
  - Write COUNT=0xFFFF_FFFE, COMPARE=5, PRESCALE=0, CTRL=0b001.
  - Required: COUNT goes 0xFFFF_FFFF, 0, 1, ...; MATCH stays 0 until COUNT passes 5, then MATCH=1 and counting continues to 6.
- Collisions:
  - Write COUNT=0x100 in the same cycle as a tick: required COUNT=0x100 afterwards.
  - Issue a W1C to STATUS in the same cycle as a match: required MATCH remains 1.
- Pipeline and reset mid-read:
  - Issue 3 consecutive read requests: required 3 consecutive resp pulses, each carrying the value at its own accept cycle.
  - Accept a read, then assert rst_ni=0 on the next edge: required no resp pulse.

Source files
------------

// File: rtl/sigma_timer_slave_if.sv
// MemSplit32 split-transaction bus between an initiator and a responder.
// The responder acks combinationally and returns read data one cycle later.
interface sigma_timer_slave_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic        bus_resp;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        input  bus_ack, bus_resp, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
        output bus_ack, bus_resp, bus_rdata
    );
endinterface

// File: rtl/sigma_timer_slave.sv
// Memory-mapped prescaled 32-bit timer with compare match flag and level irq.
// Registers: CTRL, PRESCALE, COUNT, COMPARE, STATUS at word offsets 0..4.
module sigma_timer_slave #(
    parameter int unsigned PRESC_W     = 16,
    parameter logic [31:0] RST_COMPARE = 32'hFFFF_FFFF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    sigma_timer_slave_if.slave   bus,
    output logic                 irq_o
);

    logic [2:0]         ctrl_q;
    logic [PRESC_W-1:0] prescale_q;
    logic [PRESC_W-1:0] presc_cnt_q;
    logic [31:0]        count_q;
    logic [31:0]        compare_q;
    logic               match_q;
    logic               irq_q;
    logic               resp_q;
    logic [31:0]        rdata_q;

    logic               wr_en;
    logic               rd_en;
    logic [2:0]         sel;
    logic [31:0]        rd_val;
    logic [31:0]        wr_merged;
    logic               tick;
    logic               match_hit;
    logic               unused_addr;

    assign sel         = bus.bus_addr[4:2];
    assign wr_en       = bus.bus_req & bus.bus_we;
    assign rd_en       = bus.bus_req & ~bus.bus_we;
    assign unused_addr = ^{bus.bus_addr[31:5], bus.bus_addr[1:0]};

    assign bus.bus_ack   = bus.bus_req;
    // Reset also masks a response already in flight so it never reaches the initiator.
    assign bus.bus_resp  = resp_q & rst_ni;
    assign bus.bus_rdata = rdata_q;
    assign irq_o         = irq_q;

    always_comb begin
        rd_val = '0;
        case (sel)
            3'd0:    rd_val = {29'b0, ctrl_q};
            3'd1:    rd_val = 32'(prescale_q);
            3'd2:    rd_val = count_q;
            3'd3:    rd_val = compare_q;
            3'd4:    rd_val = {31'b0, match_q};
            default: rd_val = '0;
        endcase
    end

    // Byte-masked merge of write data over the current (zero-extended) register value.
    always_comb begin
        wr_merged = rd_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.bus_be[i]) wr_merged[i*8 +: 8] = bus.bus_wdata[i*8 +: 8];
        end
    end

    assign tick      = ctrl_q[0] && (presc_cnt_q == prescale_q);
    assign match_hit = tick && (count_q == compare_q);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            ctrl_q      <= '0;
            prescale_q  <= '0;
            presc_cnt_q <= '0;
            count_q     <= '0;
            compare_q   <= RST_COMPARE;
            match_q     <= 1'b0;
            irq_q       <= 1'b0;
            resp_q      <= 1'b0;
            rdata_q     <= '0;
        end else begin
            if (wr_en && sel == 3'd1 && |bus.bus_be) begin
                presc_cnt_q <= '0;
            end else if (ctrl_q[0]) begin
                presc_cnt_q <= tick ? '0 : presc_cnt_q + PRESC_W'(1);
            end

            // A software COUNT write overrides the tick update in the same cycle.
            if (wr_en && sel == 3'd2) begin
                count_q <= wr_merged;
            end else if (tick) begin
                count_q <= (match_hit && ctrl_q[1]) ? '0 : count_q + 32'd1;
            end

            if (match_hit) begin
                match_q <= 1'b1;
            end else if (wr_en && sel == 3'd4 && bus.bus_be[0] && bus.bus_wdata[0]) begin
                match_q <= 1'b0;
            end

            if (wr_en && sel == 3'd0) ctrl_q     <= wr_merged[2:0];
            if (wr_en && sel == 3'd1) prescale_q <= wr_merged[PRESC_W-1:0];
            if (wr_en && sel == 3'd3) compare_q  <= wr_merged;

            irq_q  <= match_q & ctrl_q[2];
            resp_q <= rd_en;
            if (rd_en) rdata_q <= rd_val;
        end
    end

endmodule

// File: tb/tb_sigma_timer_slave.sv
// Directed bench for sigma_timer_slave: register access, prescaled counting,
// wrap, same-edge collisions, read pipelining and reset during a read.
module tb_sigma_timer_slave;

    logic clk;
    logic rst_ni;
    logic irq_o;
    int   n_vec;
    int   n_bad;

    sigma_timer_slave_if bus_if ();

    sigma_timer_slave #(
        .PRESC_W     (16),
        .RST_COMPARE (32'hFFFF_FFFF)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus_if),
        .irq_o  (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = 1'b1;
        bus_if.bus_addr  = a;
        bus_if.bus_wdata = d;
        bus_if.bus_be    = be;
        @(posedge clk);
        #1;
        bus_if.bus_req = 1'b0;
        bus_if.bus_we  = 1'b0;
        bus_if.bus_be  = 4'h0;
    endtask

    task automatic do_read(input logic [31:0] a, input logic [31:0] exp, input string tag);
        bus_if.bus_req  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = a;
        #1;
        chk({tag, "_ack"}, {31'b0, bus_if.bus_ack}, 32'd1);
        @(posedge clk);
        #1;
        bus_if.bus_req = 1'b0;
        chk({tag, "_resp"}, {31'b0, bus_if.bus_resp}, 32'd1);
        chk(tag, bus_if.bus_rdata, exp);
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_ni           = 1'b0;
        bus_if.bus_req   = 1'b0;
        bus_if.bus_we    = 1'b0;
        bus_if.bus_addr  = '0;
        bus_if.bus_be    = 4'h0;
        bus_if.bus_wdata = '0;

        // Reset and readback
        idle(3);
        chk("rst_resp", {31'b0, bus_if.bus_resp}, 32'd0);
        chk("rst_rdata", bus_if.bus_rdata, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        rst_ni = 1'b1;
        do_read(32'h0C, 32'hFFFF_FFFF, "rst_compare");
        chk("rst_irq2", {31'b0, irq_o}, 32'd0);
        do_read(32'h00, 32'h0, "rst_ctrl");
        do_read(32'h04, 32'h0, "rst_presc");
        do_read(32'h08, 32'h0, "rst_count");
        do_read(32'h10, 32'h0, "rst_status");

        // Byte enables, unmapped offsets, ignored address bits
        do_write(32'h0C, 32'h1234_5678, 4'b1111);
        do_write(32'h0C, 32'hAABB_CCDD, 4'b0101);
        do_read(32'h0C, 32'h12BB_56DD, "be_compare");
        do_write(32'h14, 32'hFFFF_FFFF, 4'b1111);
        do_read(32'h14, 32'h0, "unmapped_rd");
        do_read(32'hFFFF_FF2F, 32'h12BB_56DD, "alias_compare");
        do_write(32'h0C, 32'hFFFF_FFFF, 4'b0000);
        do_read(32'h0C, 32'h12BB_56DD, "be0_nowrite");

        // Prescale 3, compare 2, EN|AUTORELOAD|IRQ_EN; E<n> = n-th edge after CTRL write
        do_write(32'h04, 32'hFFFF_0003, 4'b1111);
        do_read(32'h04, 32'h3, "presc_rd");
        do_write(32'h0C, 32'h2, 4'b1111);
        do_write(32'h00, 32'h7, 4'b1111);
        do_read(32'h08, 32'h0, "cnt_e1");
        idle(2);
        do_read(32'h08, 32'h0, "cnt_e4");
        do_read(32'h08, 32'h1, "cnt_e5");
        idle(2);
        do_read(32'h08, 32'h1, "cnt_e8");
        do_read(32'h08, 32'h2, "cnt_e9");
        do_read(32'h10, 32'h0, "stat_e10");
        idle(1);
        do_read(32'h10, 32'h0, "stat_e12");
        chk("irq_e12", {31'b0, irq_o}, 32'd0);
        do_read(32'h08, 32'h0, "reload_e13");
        chk("irq_e13", {31'b0, irq_o}, 32'd1);
        do_read(32'h10, 32'h1, "match_e14");
        do_write(32'h10, 32'h1, 4'b0001);
        chk("irq_e15", {31'b0, irq_o}, 32'd1);
        do_read(32'h10, 32'h0, "w1c_e16");
        chk("irq_e16", {31'b0, irq_o}, 32'd0);

        // Free-run wrap, tick every cycle; G<n> = n-th edge after CTRL write
        do_write(32'h00, 32'h0, 4'b1111);
        do_write(32'h08, 32'hFFFF_FFFE, 4'b1111);
        do_write(32'h0C, 32'h5, 4'b1111);
        do_write(32'h04, 32'h0, 4'b1111);
        do_write(32'h00, 32'h1, 4'b1111);
        idle(1);
        do_read(32'h08, 32'hFFFF_FFFF, "wrap_g2");
        do_read(32'h08, 32'h0, "wrap_g3");
        do_read(32'h08, 32'h1, "wrap_g4");
        do_read(32'h10, 32'h0, "wrap_stat_g5");
        idle(2);
        do_read(32'h10, 32'h0, "wrap_stat_g8");
        do_read(32'h08, 32'h6, "wrap_cnt_g9");
        do_read(32'h10, 32'h1, "wrap_stat_g10");

        // COUNT write on a tick edge
        do_write(32'h08, 32'h100, 4'b1111);
        do_read(32'h08, 32'h100, "coll_count");

        // W1C on the same edge as a match
        do_write(32'h00, 32'h0, 4'b1111);
        do_write(32'h10, 32'h1, 4'b0001);
        do_read(32'h10, 32'h0, "clr_idle");
        do_write(32'h08, 32'h200, 4'b1111);
        do_write(32'h0C, 32'h202, 4'b1111);
        do_write(32'h00, 32'h1, 4'b1111);
        idle(2);
        do_write(32'h10, 32'h1, 4'b0001);
        do_read(32'h10, 32'h1, "coll_w1c");

        // Back-to-back reads with the counter running, IRQ_EN on
        do_write(32'h00, 32'h0, 4'b1111);
        do_write(32'h08, 32'h1000, 4'b1111);
        do_write(32'h00, 32'h5, 4'b1111);
        chk("wr_noresp", {31'b0, bus_if.bus_resp}, 32'd0);
        bus_if.bus_req  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = 32'h08;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i == 2) bus_if.bus_req = 1'b0;
            chk("b2b_resp", {31'b0, bus_if.bus_resp}, 32'd1);
            chk("b2b_rdata", bus_if.bus_rdata, 32'h1000 + 32'(i));
        end
        idle(1);
        chk("b2b_idle_resp", {31'b0, bus_if.bus_resp}, 32'd0);
        chk("rdata_hold", bus_if.bus_rdata, 32'h1002);
        chk("irq_pre_rst", {31'b0, irq_o}, 32'd1);

        // Reset right after a read is accepted
        bus_if.bus_req  = 1'b1;
        bus_if.bus_we   = 1'b0;
        bus_if.bus_addr = 32'h0C;
        @(posedge clk);
        #1;
        bus_if.bus_req = 1'b0;
        rst_ni = 1'b0;
        #1;
        chk("midrst_resp", {31'b0, bus_if.bus_resp}, 32'd0);
        idle(1);
        chk("midrst_resp2", {31'b0, bus_if.bus_resp}, 32'd0);
        chk("midrst_irq", {31'b0, irq_o}, 32'd0);
        chk("midrst_rdata", bus_if.bus_rdata, 32'd0);
        rst_ni = 1'b1;
        do_read(32'h0C, 32'hFFFF_FFFF, "post_rst_compare");
        do_read(32'h08, 32'h0, "post_rst_count");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
